// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice blocks: ADSR state encodings and
// saturating level arithmetic used by the envelope generator.
package synth_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned ARITH_W = 32;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_state_t;

   // min(a + b, lim), evaluated one bit wider so the sum never wraps
   function automatic logic [ARITH_W-1:0] sat_add(input logic [ARITH_W-1:0] a,
                                                  input logic [ARITH_W-1:0] b,
                                                  input logic [ARITH_W-1:0] lim);
      logic [ARITH_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, lim}) return lim;
      return sum[ARITH_W-1:0];
   endfunction

   // max(a - b, floor), without ever going below zero
   function automatic logic [ARITH_W-1:0] sat_sub(input logic [ARITH_W-1:0] a,
                                                  input logic [ARITH_W-1:0] b,
                                                  input logic [ARITH_W-1:0] floor);
      logic [ARITH_W:0] need;
      need = {1'b0, b} + {1'b0, floor};
      if ({1'b0, a} >= need) return a - b;
      return floor;
   endfunction

endpackage

// File: rtl/adsr_envelope.sv
// ADSR envelope generator. Turns a level-sensitive note gate into a linear,
// saturating amplitude envelope, stepping once per ADSR-rate tick strobe.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tick          one-cycle ramp strobe from the clock divider
//   gate          note on (1) / off (0)
//   attack        per-tick increment in ATTACK (0 = jump to full scale)
//   decay         per-tick decrement in DECAY (0 = jump to sustain)
//   sustain       sustain level
//   release_rate  per-tick decrement in RELEASE (0 = jump to zero)
//   env           registered envelope level
//   state         registered state encoding
//   busy          registered, high whenever state is not IDLE
module adsr_envelope
   import synth_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned RATE_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic                gate,
   input  logic [RATE_W-1:0]   attack,
   input  logic [RATE_W-1:0]   decay,
   input  logic [WIDTH-1:0]    sustain,
   input  logic [RATE_W-1:0]   release_rate,
   output logic [WIDTH-1:0]    env,
   output logic [STATE_W-1:0]  state,
   output logic                busy
);

   localparam logic [WIDTH-1:0] MAX_LVL = '1;

   adsr_state_t        state_q, state_n;
   logic [WIDTH-1:0]   env_q, env_n;
   logic               busy_q;

   logic [ARITH_W-1:0] env_w, max_w, sus_w;
   logic [ARITH_W-1:0] atk_res, dec_res, rel_res;

   assign env_w = ARITH_W'(env_q);
   assign max_w = ARITH_W'(MAX_LVL);
   assign sus_w = ARITH_W'(sustain);

   // Candidate ramp results; only used on tick cycles without a gate transition
   assign atk_res = sat_add(env_w, ARITH_W'(attack), max_w);
   assign dec_res = sat_sub(env_w, ARITH_W'(decay), sus_w);
   assign rel_res = sat_sub(env_w, ARITH_W'(release_rate), '0);

   // State and level registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         env_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         env_q   <= env_n;
         busy_q  <= (state_n != ST_IDLE);
      end
   end

   // Next state / level: gate transitions win over the tick and freeze env
   always_comb begin
      state_n = state_q;
      env_n   = env_q;
      case (state_q)
         ST_IDLE: begin
            if (gate) state_n = ST_ATTACK;
            else      env_n   = '0;
         end
         ST_ATTACK: begin
            if (!gate) begin
               state_n = ST_RELEASE;
            end else if (tick) begin
               if (attack == '0 || atk_res == max_w) begin
                  env_n   = MAX_LVL;
                  state_n = ST_DECAY;
               end else begin
                  env_n = WIDTH'(atk_res);
               end
            end
         end
         ST_DECAY: begin
            if (!gate) begin
               state_n = ST_RELEASE;
            end else if (tick) begin
               if (decay == '0 || dec_res == sus_w) begin
                  env_n   = sustain;
                  state_n = ST_SUSTAIN;
               end else begin
                  env_n = WIDTH'(dec_res);
               end
            end
         end
         ST_SUSTAIN: begin
            if (!gate)     state_n = ST_RELEASE;
            else if (tick) env_n   = sustain;
         end
         ST_RELEASE: begin
            if (gate) begin
               state_n = ST_ATTACK;
            end else if (tick) begin
               if (release_rate == '0 || rel_res == '0) begin
                  env_n   = '0;
                  state_n = ST_IDLE;
               end else begin
                  env_n = WIDTH'(rel_res);
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            env_n   = '0;
         end
      endcase
   end

   assign env   = env_q;
   assign state = state_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: a stimulus process drives directed and
// random cycles and pushes the reference model's expected outputs; a monitor
// pops one entry per clock and compares it to the DUT.
module tb_adsr_envelope;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned RATE_W = 8;
   localparam int MAXV = 255;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              tick = 1'b0;
   logic              gate = 1'b0;
   logic [RATE_W-1:0] attack = '0;
   logic [RATE_W-1:0] decay = '0;
   logic [WIDTH-1:0]  sustain = '0;
   logic [RATE_W-1:0] release_rate = '0;
   logic [WIDTH-1:0]  env;
   logic [2:0]        state;
   logic              busy;

   adsr_envelope #(.WIDTH(WIDTH), .RATE_W(RATE_W)) dut (
      .clk(clk), .rst(rst), .tick(tick), .gate(gate),
      .attack(attack), .decay(decay), .sustain(sustain),
      .release_rate(release_rate),
      .env(env), .state(state), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int env; int st; bit busy; } exp_t;
   exp_t sb[$];

   int checks = 0;
   int passed = 0;
   int cycle  = 0;

   // Reference model: phase 0..4 = idle/attack/decay/sustain/release
   int m_env = 0;
   int m_ph  = 0;

   function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
   function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

   task automatic model(input bit r, input bit t, input bit g,
                        input int a, input int d, input int s, input int rl);
      bit held_note;
      exp_t e;
      if (r) begin
         m_env = 0;
         m_ph  = 0;
      end else begin
         held_note = (m_ph == 1 || m_ph == 2 || m_ph == 3);
         if (g && !held_note) begin
            m_ph = 1;                       // note on restarts attack from current level
         end else if (!g && held_note) begin
            m_ph = 4;                       // note off
         end else if (t) begin
            if (m_ph == 1) begin
               m_env = (a == 0) ? MAXV : imin(m_env + a, MAXV);
               if (m_env == MAXV) m_ph = 2;
            end else if (m_ph == 2) begin
               m_env = (d == 0) ? s : imax(m_env - d, s);
               if (m_env == s) m_ph = 3;
            end else if (m_ph == 3) begin
               m_env = s;
            end else if (m_ph == 4) begin
               m_env = (rl == 0) ? 0 : imax(m_env - rl, 0);
               if (m_env == 0) m_ph = 0;
            end else begin
               m_env = 0;
            end
         end
      end
      e.env  = m_env;
      e.st   = m_ph;
      e.busy = (m_ph != 0);
      sb.push_back(e);
   endtask

   task automatic step(input bit r, input bit t, input bit g,
                       input int a, input int d, input int s, input int rl);
      @(negedge clk);
      rst = r; tick = t; gate = g;
      attack = RATE_W'(a); decay = RATE_W'(d);
      sustain = WIDTH'(s); release_rate = RATE_W'(rl);
      model(r, t, g, a, d, s, rl);
   endtask

   // Monitor: the DUT presents a new output every clock
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (int'(env) != e.env || int'(state) != e.st || busy != e.busy)
               $display("FAIL output cycle %0d: got env=%0d state=%0d busy=%0b, want env=%0d state=%0d busy=%0b",
                        cycle, env, state, busy, e.env, e.st, e.busy);
            else
               passed++;
         end
      end
   end

   initial begin
      int a, d, s, rl;
      bit g;
      // Reset with gate held high, then release
      step(1, 0, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 64, 50, 100, 40);
      // Attack 64/tick: 64,128,192,255 -> DECAY
      repeat (4) step(0, 1, 1, 64, 50, 100, 40);
      // Decay 50 to sustain 100: 205,155,105,100 -> SUSTAIN
      repeat (4) step(0, 1, 1, 64, 50, 100, 40);
      step(0, 1, 1, 64, 50, 80, 40);
      step(0, 1, 1, 64, 50, 100, 40);
      // Note off on a tick cycle: env holds at 100
      step(0, 1, 0, 64, 50, 100, 40);
      repeat (3) step(0, 1, 0, 64, 50, 100, 40);
      step(0, 0, 0, 64, 50, 100, 40);
      // Instant attack and decay, then retrigger during release at 60
      step(0, 0, 1, 0, 0, 100, 40);
      step(0, 1, 1, 0, 0, 100, 40);
      step(0, 1, 1, 0, 0, 100, 40);
      step(0, 1, 0, 0, 0, 100, 40);
      step(0, 1, 0, 0, 0, 100, 40);
      step(0, 1, 1, 0, 0, 100, 40);
      step(0, 1, 1, 0, 0, 100, 40);
      // No ticks: level frozen
      repeat (10) step(0, 0, 1, 0, 0, 100, 40);
      // Boundaries: sustain at full scale and at zero
      step(0, 1, 1, 0, 10, 255, 40);
      step(0, 1, 1, 0, 10, 255, 40);
      step(0, 1, 0, 0, 10, 255, 0);
      step(0, 1, 0, 0, 10, 255, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      repeat (4) step(0, 1, 1, 0, 0, 0, 0);
      // Mid-ramp reset
      step(0, 0, 0, 0, 0, 0, 7);
      step(0, 1, 0, 0, 0, 0, 7);
      step(0, 0, 1, 30, 0, 0, 7);
      step(0, 1, 1, 30, 0, 0, 7);
      step(1, 1, 1, 30, 0, 0, 7);
      step(0, 0, 1, 30, 0, 0, 7);
      // Randomized run
      g = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) g = ~g;
         a  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 90));
         d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 90));
         rl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 90));
         case ($urandom_range(0, 5))
            0:       s = 0;
            1:       s = MAXV;
            default: s = int'($urandom_range(0, 255));
         endcase
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), g, a, d, s, rl);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expected entries left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
